// File: rtl/jtkicker_pkg.sv
// Shared definitions for the Kicker graphics ROM requesters: FSM encoding
// and the SDRAM half-word base of each graphics ROM region.
package jtkicker_pkg;

  localparam int SDRAM_AW_DEF = 22;

  localparam logic [SDRAM_AW_DEF-1:0] TILE_ROM_OFFSET = 22'h00_0000;
  localparam logic [SDRAM_AW_DEF-1:0] OBJ_ROM_OFFSET  = 22'h01_0000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_BEAT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_BEAT1 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_REQ   = S_REQ,
    ST_BEAT0 = S_BEAT0,
    ST_REQ1  = S_REQ1,
    ST_BEAT1 = S_BEAT1
  } romrq_state_t;

endpackage

// File: rtl/jtkicker_tile_romrq.sv
// Single-entry cache in front of the SDRAM: turns 32-bit word requests from a
// graphics layer into two 16-bit SDRAM reads (low half first).
module jtkicker_tile_romrq
  import jtkicker_pkg::*;
#(
  parameter int                  AW       = 13,
  parameter int                  SDRAM_AW = SDRAM_AW_DEF,
  parameter logic [SDRAM_AW-1:0] OFFSET   = TILE_ROM_OFFSET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_cs,
  input  logic [AW-1:0]       rom_addr,
  output logic [31:0]         rom_data,
  output logic                rom_ok,
  input  logic                downloading,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         sdram_din
);

  romrq_state_t        state_q;
  logic [AW-1:0]       req_addr_q;
  logic [AW-1:0]       tag_q;
  logic                valid_q;
  logic [31:0]         data_q;
  logic [SDRAM_AW-1:0] sdram_addr_q;
  logic                sdram_req_q;

  logic                hit;
  logic                miss;
  logic [SDRAM_AW-1:0] base_cur;
  logic [SDRAM_AW-1:0] base_req;

  // Word address -> half-word address; wraps modulo 2^SDRAM_AW.
  assign base_cur = OFFSET + SDRAM_AW'({rom_addr, 1'b0});
  assign base_req = OFFSET + SDRAM_AW'({req_addr_q, 1'b0});

  assign hit  = valid_q && (tag_q == rom_addr);
  assign miss = rom_cs && !downloading && !hit;

  // Combinational so a changed address drops rom_ok in the same cycle.
  assign rom_ok     = hit && rom_cs && !downloading;
  assign rom_data   = data_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_req  = sdram_req_q;

  // NOTE: every register here uses <= so all state updates see the pre-edge
  // values; blocking assignments would make the case order matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      sdram_addr_q <= '0;
      sdram_req_q  <= 1'b0;
    end else begin
      if (downloading) valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (miss) begin
          req_addr_q   <= rom_addr;
          sdram_addr_q <= base_cur;
          sdram_req_q  <= 1'b1;
          valid_q      <= 1'b0;
          state_q      <= ST_REQ;
        end
        ST_REQ: if (sdram_ack) begin
          sdram_req_q <= 1'b0;
          state_q     <= ST_BEAT0;
        end
        ST_BEAT0: if (data_rdy) begin
          data_q[15:0] <= sdram_din;
          sdram_addr_q <= base_req + SDRAM_AW'(1);
          sdram_req_q  <= 1'b1;
          state_q      <= ST_REQ1;
        end
        ST_REQ1: if (sdram_ack) begin
          sdram_req_q <= 1'b0;
          state_q     <= ST_BEAT1;
        end
        ST_BEAT1: if (data_rdy) begin
          // A fetch that overlapped a ROM download completes but stays invalid.
          data_q[31:16] <= sdram_din;
          tag_q         <= req_addr_q;
          valid_q       <= !downloading;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_tile_romrq.sv
// Directed bench for jtkicker_tile_romrq: cold miss, hit, mid-fetch address
// change, delayed ack, download invalidation and reset mid-fetch.
module tb_jtkicker_tile_romrq;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_cs;
  logic [12:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic        downloading;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] sdram_din;

  int n_cmp = 0;
  int n_err = 0;

  logic req_prev = 1'b0;
  int   req_rises = 0;

  always #5 clk = ~clk;

  jtkicker_tile_romrq #(
    .AW      (13),
    .SDRAM_AW(22),
    .OFFSET  (22'h10000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .downloading(downloading),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_din  (sdram_din)
  );

  // Counts requests issued, as seen by the arbiter at each clock edge.
  always @(posedge clk) begin
    if (sdram_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= sdram_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic do_beat(input logic [15:0] d);
    data_rdy  = 1'b1;
    sdram_din = d;
    tick();
    data_rdy  = 1'b0;
  endtask

  initial begin
    int   rises0;
    logic stable;

    rst = 1'b1; rom_cs = 1'b1; rom_addr = 13'h0123; downloading = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = 16'h0;
    tick(); tick(); tick();
    check("rst_req",  {31'd0, sdram_req}, 32'd0);
    check("rst_addr", {10'd0, sdram_addr}, 32'd0);
    check("rst_data", rom_data, 32'd0);
    check("rst_ok",   {31'd0, rom_ok}, 32'd0);

    // Cold miss
    rises0 = req_rises;
    rst = 1'b0;
    #1;
    check("cold_req_not_yet", {31'd0, sdram_req}, 32'd0);
    tick();
    check("cold_req",   {31'd0, sdram_req}, 32'd1);
    check("cold_addr0", {10'd0, sdram_addr}, 32'h10246);
    do_ack();
    check("cold_req_drop", {31'd0, sdram_req}, 32'd0);
    check("cold_ok_busy",  {31'd0, rom_ok}, 32'd0);
    do_beat(16'hBEEF);
    check("cold_req1",  {31'd0, sdram_req}, 32'd1);
    check("cold_addr1", {10'd0, sdram_addr}, 32'h10247);
    do_ack();
    do_beat(16'hCAFE);
    check("cold_ok",    {31'd0, rom_ok}, 32'd1);
    check("cold_data",  rom_data, 32'hCAFEBEEF);
    check("cold_nreq",  req_rises - rises0, 32'd2);

    // Hit: no traffic while the address holds
    rises0 = req_rises;
    for (int i = 0; i < 5; i++) tick();
    check("hit_ok",   {31'd0, rom_ok}, 32'd1);
    check("hit_req",  {31'd0, sdram_req}, 32'd0);
    check("hit_nreq", req_rises - rises0, 32'd0);
    rom_addr = 13'h0124;
    #1;
    check("chg_ok_drop", {31'd0, rom_ok}, 32'd0);
    tick();
    check("chg_req",  {31'd0, sdram_req}, 32'd1);
    check("chg_addr", {10'd0, sdram_addr}, 32'h10248);
    do_ack(); do_beat(16'h1111); do_ack(); do_beat(16'h2222);
    check("chg_data", rom_data, 32'h22221111);
    check("chg_ok",   {31'd0, rom_ok}, 32'd1);

    // Address change during BEAT0
    rom_addr = 13'h0010;
    tick();
    check("mid_addr0", {10'd0, sdram_addr}, 32'h10020);
    do_ack();
    rom_addr = 13'h0011;
    #1;
    do_beat(16'hAAAA);
    check("mid_addr1", {10'd0, sdram_addr}, 32'h10021);
    do_ack();
    check("mid_ok_busy", {31'd0, rom_ok}, 32'd0);
    do_beat(16'hBBBB);
    check("mid_ok_stale", {31'd0, rom_ok}, 32'd0);
    tick();
    check("mid_refetch_req",  {31'd0, sdram_req}, 32'd1);
    check("mid_refetch_addr", {10'd0, sdram_addr}, 32'h10022);
    do_ack(); do_beat(16'h3333); do_ack();
    check("mid_ok_b1", {31'd0, rom_ok}, 32'd0);
    do_beat(16'h4444);
    check("mid_ok",   {31'd0, rom_ok}, 32'd1);
    check("mid_data", rom_data, 32'h44443333);

    // Delayed ack, plus a data_rdy coincident with ack that must be ignored
    rises0 = req_rises;
    rom_addr = 13'h0200;
    tick();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req !== 1'b1 || sdram_addr !== 22'h10400) stable = 1'b0;
      tick();
    end
    check("dly_stable", {31'd0, stable}, 32'd1);
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 16'hDEAD;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    check("dly_ignore_req", {31'd0, sdram_req}, 32'd0);
    do_beat(16'h5555);
    check("dly_addr1", {10'd0, sdram_addr}, 32'h10401);
    do_ack(); do_beat(16'h6666);
    check("dly_data", rom_data, 32'h66665555);
    check("dly_ok",   {31'd0, rom_ok}, 32'd1);
    check("dly_nreq", req_rises - rises0, 32'd2);

    // Download invalidates a valid entry
    downloading = 1'b1;
    #1;
    check("dl_ok_drop", {31'd0, rom_ok}, 32'd0);
    tick(); tick(); tick();
    check("dl_no_req", {31'd0, sdram_req}, 32'd0);
    downloading = 1'b0;
    #1;
    check("dl_invalid", {31'd0, rom_ok}, 32'd0);
    tick();
    check("dl_refetch_req",  {31'd0, sdram_req}, 32'd1);
    check("dl_refetch_addr", {10'd0, sdram_addr}, 32'h10400);
    do_ack(); do_beat(16'h7777); do_ack(); do_beat(16'h8888);
    check("dl_data", rom_data, 32'h88887777);
    check("dl_ok",   {31'd0, rom_ok}, 32'd1);

    // Download rising mid-fetch: fetch completes, result discarded
    rom_addr = 13'h0300;
    tick();
    check("dlmid_addr0", {10'd0, sdram_addr}, 32'h10600);
    do_ack();
    downloading = 1'b1;
    do_beat(16'h9999); do_ack(); do_beat(16'h0F0F);
    check("dlmid_req", {31'd0, sdram_req}, 32'd0);
    downloading = 1'b0;
    #1;
    check("dlmid_discard", {31'd0, rom_ok}, 32'd0);
    tick();
    check("dlmid_refetch", {31'd0, sdram_req}, 32'd1);
    do_ack(); do_beat(16'h1234); do_ack(); do_beat(16'h5678);
    check("dlmid_data", rom_data, 32'h56781234);

    // rom_cs low in IDLE issues nothing
    rom_cs = 1'b0; rom_addr = 13'h0400;
    tick(); tick();
    check("cs_low_req", {31'd0, sdram_req}, 32'd0);
    check("cs_low_ok",  {31'd0, rom_ok}, 32'd0);

    // Reset during BEAT1
    rom_cs = 1'b1;
    tick();
    check("rmid_addr0", {10'd0, sdram_addr}, 32'h10800);
    do_ack(); do_beat(16'hABCD); do_ack();
    rst = 1'b1;
    tick();
    check("rmid_req",  {31'd0, sdram_req}, 32'd0);
    check("rmid_ok",   {31'd0, rom_ok}, 32'd0);
    check("rmid_data", rom_data, 32'd0);
    rst = 1'b0; rom_cs = 1'b0;
    do_beat(16'hF00D);
    check("rmid_stray_data", rom_data, 32'd0);
    check("rmid_stray_req",  {31'd0, sdram_req}, 32'd0);
    rom_cs = 1'b1;
    tick();
    check("rmid_idle_req",  {31'd0, sdram_req}, 32'd1);
    check("rmid_idle_addr", {10'd0, sdram_addr}, 32'h10800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
